regfile_2r1w_param: RTL

REGFILE_2R1W_PARAM -- requirements
Module: regfile_2r1w_param

---
 rtl/regfile_2r1w_param.sv | 136 +++++++++++++
 1 files changed

// File: rtl/regfile_2r1w_param.sv
// Parameterised 2-read/1-write register file with write-first bypass
// and a sequential clear engine that zeroes one entry per cycle.
module regfile_2r1w_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_w,
  input  logic [AW-1:0]    address_w,
  input  logic [WIDTH-1:0] In,
  input  logic             enable_a,
  input  logic [AW-1:0]    address_a,
  input  logic             enable_b,
  input  logic [AW-1:0]    address_b,
  input  logic             clr_req,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             valid_a,
  output logic             valid_b,
  output logic             busy
);

  if (2**AW < DEPTH) begin : g_aw_check
    $error("AW too small for DEPTH");
  end

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  state_t           state_nx;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             wr_ok;
  logic             rd_a;
  logic             rd_b;

  // An address is live when it maps to a real, writable entry.
  function automatic logic live(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign busy  = (state == CLEAR);
  assign wr_ok = enable_w && !busy && live(address_w);
  assign rd_a  = enable_a && !busy;
  assign rd_b  = enable_b && !busy;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
      CLEAR: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + AW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy && cnt == AW'(i))
          mem[i] <= '0;
        else if (wr_ok && address_w == AW'(i))
          mem[i] <= In;
      end
    end
  end

  // Write-first: a live same-cycle write overrides the stored value.
  always_comb begin
    data_a = '0;
    for (int i = 0; i < DEPTH; i++)
      if (address_a == AW'(i)) data_a = mem[i];
    if (!live(address_a))
      data_a = '0;
    else if (wr_ok && address_w == address_a)
      data_a = In;
  end

  always_comb begin
    data_b = '0;
    for (int i = 0; i < DEPTH; i++)
      if (address_b == AW'(i)) data_b = mem[i];
    if (!live(address_b))
      data_b = '0;
    else if (wr_ok && address_w == address_b)
      data_b = In;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutA    <= '0;
      OutB    <= '0;
      valid_a <= 1'b0;
      valid_b <= 1'b0;
    end else begin
      valid_a <= rd_a;
      valid_b <= rd_b;
      if (rd_a) OutA <= data_a;
      if (rd_b) OutB <= data_b;
    end
  end

endmodule
